// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl
// Front-end sequencer that sits beside the PC register. It steers the PC
// write/select, the fetch/decode buffer enable/flush and the decode/execute
// bubble. It resolves load-use stalls, taken-branch flushes and a multi-step
// interrupt entry (drain, push PC, push flags, load vector).
//
// Optional feature: define FSC_HALT_EN to let a decoded HLT park the core
// until an interrupt arrives. Without it, halt_dec is ignored and halted
// is tied to 0.
//
// Outputs are combinational from the registered state and the current
// inputs. The pipeline buffers sample them on the falling edge.

module fetch_stage_ctrl #(
    parameter int REG_W        = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_req,
    input  logic             ex_branch_taken,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic [REG_W-1:0] if_id_rs1,
    input  logic [REG_W-1:0] if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic             halt_dec,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             fd_enable,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             int_inject,
    output logic [1:0]       int_step,
    output logic             int_busy,
    output logic             int_pending,
    output logic             halted
);

    // PC source encodings
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_VECTOR = 2'b10;

    // Interrupt micro-step encodings driven alongside int_inject
    localparam logic [1:0] STEP_NONE     = 2'b00;
    localparam logic [1:0] STEP_PUSH_PC  = 2'b01;
    localparam logic [1:0] STEP_PUSH_FLG = 2'b10;
    localparam logic [1:0] STEP_VECTOR   = 2'b11;

    // The drain counter counts down to zero, so it is loaded with one less
    // than the number of bubble cycles wanted.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_PC,
        PUSH_FLG,
        VECTOR
    } state_t;

    state_t     state_q;
    state_t     state_next;
    logic [3:0] drain_cnt_q;
    logic [3:0] drain_cnt_next;
    logic       pending_q;
    logic       pending_next;
    logic       halted_q;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;

    // Load-use hazard: the load in EX writes a register the decode
    // instruction reads; rs2 only counts when decode actually uses it.
    always_comb begin
        rs1_hit  = (id_ex_rd == if_id_rs1);
        rs2_hit  = if_id_uses_rs2 && (id_ex_rd == if_id_rs2);
        load_use = id_ex_mem_read && (rs1_hit || rs2_hit);
    end

    // Next-state logic for the sequencer, drain counter and pending flag
    always_comb begin
        state_next     = state_q;
        drain_cnt_next = drain_cnt_q;
        pending_next   = pending_q | int_req;

        case (state_q)
            IDLE: begin
                if (!halted_q && ex_branch_taken) begin
                    // A taken branch wins; a pending interrupt waits one
                    // cycle so the saved PC is the branch target.
                    state_next = IDLE;
                end else if (pending_q) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end

            DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_next = PUSH_PC;
                end else begin
                    drain_cnt_next = drain_cnt_q - 4'd1;
                end
            end

            PUSH_PC: begin
                state_next = PUSH_FLG;
            end

            PUSH_FLG: begin
                state_next = VECTOR;
            end

            VECTOR: begin
                // Requests that arrived while busy merge into the one
                // being serviced, so the flag drops here unconditionally.
                state_next   = IDLE;
                pending_next = 1'b0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, drain counter and pending flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= 4'd0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_next;
            drain_cnt_q <= drain_cnt_next;
            pending_q   <= pending_next;
        end
    end

`ifdef FSC_HALT_EN
    logic halted_next;

    // A halt latches from IDLE and only a pending interrupt releases it
    always_comb begin
        halted_next = halted_q;
        if (state_q == IDLE) begin
            if (halted_q) begin
                if (pending_q) begin
                    halted_next = 1'b0;
                end
            end else if (!ex_branch_taken && !pending_q && halt_dec) begin
                halted_next = 1'b1;
            end
        end
    end

    // Halted flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_next;
        end
    end
`else
    logic unused_halt_dec;

    assign unused_halt_dec = halt_dec;
    assign halted_q        = 1'b0;
`endif

    // Output decode from state, halt flag and hazard inputs
    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        fd_enable  = 1'b1;
        fd_flush   = 1'b0;
        de_bubble  = 1'b0;
        int_inject = 1'b0;
        int_step   = STEP_NONE;
        int_busy   = 1'b0;

        if (!rst) begin
            // Keep NOPs flowing into both buffers while reset is held
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (halted_q) begin
                        fd_enable = 1'b0;
                        de_bubble = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_write  = 1'b1;
                        pc_sel    = PC_SEL_BRANCH;
                        fd_flush  = 1'b1;
                        de_bubble = 1'b1;
                    end else if (pending_q) begin
                        pc_write = 1'b1;
                    end else if (load_use) begin
                        fd_enable = 1'b0;
                        de_bubble = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end

                DRAIN: begin
                    int_busy  = 1'b1;
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end

                PUSH_PC: begin
                    int_busy   = 1'b1;
                    int_inject = 1'b1;
                    int_step   = STEP_PUSH_PC;
                end

                PUSH_FLG: begin
                    int_busy   = 1'b1;
                    int_inject = 1'b1;
                    int_step   = STEP_PUSH_FLG;
                end

                VECTOR: begin
                    int_busy = 1'b1;
                    int_step = STEP_VECTOR;
                    pc_sel   = PC_SEL_VECTOR;
                    pc_write = 1'b1;
                    fd_flush = 1'b1;
                end

                default: begin
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end
            endcase
        end
    end

    assign int_pending = pending_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl
// Directed bench for fetch_stage_ctrl with hand-computed expectations.
// Inputs change 1 time unit after a rising edge and outputs are checked
// 1 time unit later, well clear of the active edge.

module tb_fetch_stage_ctrl;

    localparam int REG_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             int_req;
    logic             ex_branch_taken;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rd;
    logic [REG_W-1:0] if_id_rs1;
    logic [REG_W-1:0] if_id_rs2;
    logic             if_id_uses_rs2;
    logic             halt_dec;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             fd_enable;
    logic             fd_flush;
    logic             de_bubble;
    logic             int_inject;
    logic [1:0]       int_step;
    logic             int_busy;
    logic             int_pending;
    logic             halted;

    int testsRun    = 0;
    int testsFailed = 0;

    // {int_busy, int_inject, int_step, pc_sel, pc_write, fd_flush}
    logic [7:0] seqObs;
    assign seqObs = {int_busy, int_inject, int_step, pc_sel, pc_write, fd_flush};

    // Expected seqObs for cycles N+1..N+7 after int_req is sampled at edge N
    logic [7:0] intSeqExp [7] = '{8'h81, 8'h81, 8'h81, 8'hD0, 8'hE0, 8'hBB, 8'h02};

    always #5 clk = ~clk;

    fetch_stage_ctrl #(
        .REG_W       (REG_W),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .int_req        (int_req),
        .ex_branch_taken(ex_branch_taken),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .halt_dec       (halt_dec),
        .pc_write       (pc_write),
        .pc_sel         (pc_sel),
        .fd_enable      (fd_enable),
        .fd_flush       (fd_flush),
        .de_bubble      (de_bubble),
        .int_inject     (int_inject),
        .int_step       (int_step),
        .int_busy       (int_busy),
        .int_pending    (int_pending),
        .halted         (halted)
    );

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every functional input in one call
    task automatic applyStimulus(input logic branch, input logic memRead,
                                 input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                                 input logic [REG_W-1:0] rs2, input logic usesRs2,
                                 input logic intReq, input logic haltDec);
        ex_branch_taken = branch;
        id_ex_mem_read  = memRead;
        id_ex_rd        = rd;
        if_id_rs1       = rs1;
        if_id_rs2       = rs2;
        if_id_uses_rs2  = usesRs2;
        int_req         = intReq;
        halt_dec        = haltDec;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hard bound on the run in case the DUT or bench stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vectorCount;
        int firstBusy;

        rst = 1'b0;
        idleStimulus();

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_pc_write",  pc_write,  1'b0);
        checkOutput("rst_fd_flush",  fd_flush,  1'b1);
        checkOutput("rst_de_bubble", de_bubble, 1'b1);
        checkOutput("rst_fd_enable", fd_enable, 1'b1);
        checkOutput("rst_int_busy",  int_busy,  1'b0);
        checkOutput("rst_int_step",  int_step,  2'b00);
        rst = 1'b1;
        #1;
        checkOutput("rel_pc_write", pc_write, 1'b1);
        checkOutput("rel_pc_sel",   pc_sel,   2'b00);
        checkOutput("rel_flush",    {fd_flush, de_bubble}, 2'b00);

        // ---------------- load-use on rs1 ----------------
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rs1_stall", {pc_write, fd_enable, de_bubble}, 3'b001);
        nextCycle();
        idleStimulus();
        #1;
        checkOutput("lu_rs1_resume", {pc_write, fd_enable, de_bubble}, 3'b110);

        // ---------------- rs2 gating ----------------
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rs2_unused_nostall", {pc_write, fd_enable, de_bubble}, 3'b110);
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("rs2_used_stall", {pc_write, fd_enable, de_bubble}, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("no_load_nostall", {pc_write, fd_enable, de_bubble}, 3'b110);

        // ---------------- taken branch ----------------
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br_outputs", {pc_sel, pc_write, fd_enable, fd_flush, de_bubble}, 6'b011111);
        applyStimulus(1'b1, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br_over_loaduse", {pc_sel, pc_write}, 3'b011);

        // ---------------- interrupt entry ----------------
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleStimulus();
        #1;
        checkOutput("int_latched",  int_pending, 1'b1);
        checkOutput("int_gap_fetch", {int_busy, pc_write}, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            if (k == 2) begin
                // Branch, hazard and a repeat request during DRAIN are ignored/merged
                applyStimulus(1'b1, 1'b1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0);
            end else begin
                idleStimulus();
            end
            #1;
            checkOutput($sformatf("int_seq_n%0d", k), seqObs, intSeqExp[k-1]);
        end
        checkOutput("int_merged_cleared", int_pending, 1'b0);
        nextCycle();
        #1;
        checkOutput("int_no_reentry", int_busy, 1'b0);

        // ---------------- pending deferred by a branch ----------------
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("defer_branch", {int_busy, pc_sel, pc_write}, 4'b0011);
        nextCycle();
        idleStimulus();
        #1;
        checkOutput("defer_gap", {int_busy, int_pending, pc_write}, 3'b011);
        nextCycle();
        #1;
        checkOutput("defer_drain", seqObs, 8'h81);
        repeat (5) nextCycle();
        #1;
        checkOutput("defer_vector", seqObs, 8'hBB);
        nextCycle();
        #1;
        checkOutput("defer_done", {int_busy, int_pending}, 2'b00);

        // ---------------- branch and int_req together ----------------
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("coll_branch_first", {int_busy, pc_sel, pc_write}, 4'b0011);
        nextCycle();
        idleStimulus();
        #1;
        checkOutput("coll_pending", {int_busy, int_pending}, 2'b01);
        vectorCount = 0;
        firstBusy   = -1;
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            #1;
            if (int_busy && firstBusy < 0) firstBusy = i;
            if (int_step == 2'b11) vectorCount++;
        end
        checkOutput("coll_drain_next",  firstBusy,   0);
        checkOutput("coll_single_seq",  vectorCount, 1);

        // ---------------- reset during PUSH_PC ----------------
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleStimulus();
        repeat (4) nextCycle();
        #1;
        checkOutput("mid_push_pc", {int_inject, int_step}, 3'b101);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_abort", {int_inject, int_busy, pc_write, fd_flush, de_bubble},
                    5'b00011);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_idle", {int_busy, int_pending, pc_write, pc_sel}, 5'b00100);

        // ---------------- halt request ----------------
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1);
        nextCycle();
        #1;
`ifdef FSC_HALT_EN
        checkOutput("halt_state", {halted, pc_write, fd_enable, de_bubble}, 4'b1001);
`else
        checkOutput("halt_state", {halted, pc_write, fd_enable, de_bubble}, 4'b0110);
`endif
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleStimulus();
        nextCycle();
        #1;
        checkOutput("halt_int_exit", {halted, int_busy}, 2'b01);
        repeat (6) nextCycle();
        #1;
        checkOutput("halt_int_done", {halted, int_busy, pc_write}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
